imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning number of 32-bit words in the attached instruction RAM.
REQ-002 SHALL have parameter IDX_W, default 6, meaning word-index width (log2 DEPTH).
REQ-003 SHALL have one clock and one reset: clk and rst; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 f_req  input  1  fetch-port read request from the CPU.
REQ-007 f_addr  input  32  fetch byte address.
REQ-008 f_gnt  output  1  fetch request accepted this cycle.
REQ-009 f_rvalid  output  1  f_rdata valid, one-cycle pulse.
REQ-010 f_rdata  output  32  fetched instruction word.
REQ-011 l_req  input  1  loader-port write request for program download.
REQ-012 l_addr  input  32  loader byte address.
REQ-013 l_wdata  input  32  loader write data.
REQ-014 l_gnt  output  1  loader request accepted this cycle.
REQ-015 mem_en  output  1  RAM access enable.
REQ-016 mem_we  output  1  RAM write enable.
REQ-017 mem_idx  output  IDX_W  RAM word index.
REQ-018 mem_wdata  output  32  RAM write data.
REQ-019 mem_rdata  input  32  RAM read data, valid the cycle after mem_en with mem_we low.
REQ-020 err  output  1  out-of-range access flag, one-cycle pulse (REQ-036).

Function
REQ-021 SHALL implement FSM states IDLE, READ, RESP, WRITE.
REQ-022 f_gnt and l_gnt SHALL be combinational, asserted only in IDLE, and never both in the same cycle.
REQ-023 In IDLE, a single requester SHALL be granted in that cycle, and its address/data SHALL be latched at the edge.
REQ-024 If f_req and l_req are both high in IDLE, the port not granted most recently SHALL win; the last-grant register SHALL reset to "loader", so fetch wins the first tie.
REQ-025 Fetch grant SHALL take IDLE to READ, which drives mem_en=1, mem_we=0, mem_idx=latched addr[IDX_W+1:2], then to RESP.
REQ-026 RESP SHALL drive f_rvalid=1 with f_rdata=mem_rdata, then return to IDLE.
REQ-027 Fetch latency SHALL be f_rvalid asserted exactly 2 cycles after the grant edge.
REQ-028 Loader grant SHALL take IDLE to WRITE, which drives mem_en=1, mem_we=1, mem_idx, mem_wdata=latched data, then returns to IDLE.
REQ-029 Outside READ and WRITE, mem_en, mem_we, mem_idx and mem_wdata SHALL be 0.
REQ-030 Address bits [1:0] SHALL always be ignored (word-aligned access).
REQ-031 Requests arriving outside IDLE SHALL wait; a requester SHALL hold req, addr and data stable until granted.
REQ-032 f_rdata SHALL be 0 whenever f_rvalid is low.

Reset
REQ-033 Reset SHALL put the FSM in IDLE and set every output to 0 (f_rdata=0x00000000).
REQ-034 Reset during READ or RESP SHALL discard the in-flight fetch with no f_rvalid; reset during WRITE SHALL deassert mem_we the following cycle.

Configuration
REQ-035 Without IMEM_ARB_RANGE_CHK_EN, address bits above IDX_W+1 SHALL be ignored, so indices wrap modulo DEPTH, and err SHALL be tied to 0.
REQ-036 With IMEM_ARB_RANGE_CHK_EN, an access with byte address >= 4*DEPTH SHALL still be granted, but:
- write: no mem_en/mem_we is issued;
- fetch: RESP returns 0x00000013 (NOP) with no mem_en;
- err pulses in the WRITE or RESP cycle.

Structure
REQ-037 Package imem_pkg SHALL hold the FSM state enum, IMEM_DEPTH=64, and NOP_INSTR=32'h00000013.
REQ-038 Sub-module imem_rr_pick SHALL implement the 2-way round-robin picker (inputs: two requests plus last-grant; output: one-hot grant); RAM storage is external.

Verification
REQ-039 Fetch only: f_req=1, f_addr=0x08 with RAM word 2=0x002081b3 -> f_gnt in cycle 0, mem_idx=2 in cycle 1, f_rvalid with f_rdata=0x002081b3 in cycle 2.
REQ-040 Loader only: l_addr=0x24, l_wdata=0x02a00413 -> one cycle of mem_we=1 with mem_idx=9 and mem_wdata=0x02a00413; a subsequent fetch of 0x24 returns 0x02a00413.
REQ-041 Both ports requesting continuously from reset -> grants alternate F, L, F, L; neither port is starved.
REQ-042 rst asserted in the READ cycle -> no f_rvalid, all outputs 0 the next cycle, FSM in IDLE.
REQ-043 Address 0x100 -> without macro: mem_idx=0; with macro: no mem_en, fetch returns 0x00000013, err pulses once.

Source files
------------

// File: rtl/imem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg : shared types and constants for the instruction-memory arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package imem_pkg;

  localparam int          IMEM_DEPTH = 64;
  localparam logic [31:0] NOP_INSTR  = 32'h00000013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_RESP  = 2'd2,
    ST_WRITE = 2'd3
  } imem_state_e;

endpackage

`default_nettype wire

// File: rtl/imem_arbiter_if.sv
// ---------------------------------------------------------------------------
// imem_arbiter_if : fetch, loader and RAM-side signals of the imem arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface imem_arbiter_if #(
  parameter int IDX_W = 6
) ();

  logic             f_req;
  logic [31:0]      f_addr;
  logic             f_gnt;
  logic             f_rvalid;
  logic [31:0]      f_rdata;
  logic             l_req;
  logic [31:0]      l_addr;
  logic [31:0]      l_wdata;
  logic             l_gnt;
  logic             mem_en;
  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;
  logic             err;

  // Arbiter view: requests and RAM read data in, grants and RAM controls out
  modport slave (
    input  f_req, f_addr, l_req, l_addr, l_wdata, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, l_gnt, mem_en, mem_we, mem_idx, mem_wdata, err
  );

  modport master (
    output f_req, f_addr, l_req, l_addr, l_wdata, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, l_gnt, mem_en, mem_we, mem_idx, mem_wdata, err
  );

endinterface

`default_nettype wire

// File: rtl/imem_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// imem_rr_pick : 2-way round-robin picker, one-hot grant {loader, fetch}
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imem_rr_pick (
  input  logic       f_req_i,
  input  logic       l_req_i,
  input  logic       last_l_i,
  output logic [1:0] gnt_o
);

  logic w_f_win;

  // On a tie the port that did not win last time takes the grant
  assign w_f_win = f_req_i & (~l_req_i | last_l_i);
  assign gnt_o   = {l_req_i & ~w_f_win, w_f_win};

endmodule

`default_nettype wire

// File: rtl/imem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_arbiter : arbitrates CPU fetch and program-loader access to one RAM.
// Optional IMEM_ARB_RANGE_CHK_EN blocks out-of-range accesses and pulses err.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imem_arbiter
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int IDX_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  imem_arbiter_if.slave  bus
);

  imem_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             last_l_q, last_l_d;

  logic             w_idle;
  logic [1:0]       w_pick;
  logic             w_oor_hold;
  logic             w_unused_bits;

  // Grants are withheld during reset because the reset edge would drop them
  assign w_idle = (state_q == ST_IDLE) & ~rst;

  imem_rr_pick u_pick (
    .f_req_i  (bus.f_req & w_idle),
    .l_req_i  (bus.l_req & w_idle),
    .last_l_i (last_l_q),
    .gnt_o    (w_pick)
  );

`ifdef IMEM_ARB_RANGE_CHK_EN
  logic        oor_q;
  logic [31:0] w_sel_addr;
  logic        w_oor_now;

  assign w_sel_addr = w_pick[0] ? bus.f_addr : bus.l_addr;
  assign w_oor_now  = {2'b00, w_sel_addr[31:2]} >= 32'(DEPTH);
  assign w_oor_hold = oor_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      oor_q <= 1'b0;
    end else if (w_pick != 2'b00) begin
      oor_q <= w_oor_now;
    end
  end
`else
  assign w_oor_hold = 1'b0;
`endif

  // Byte-lane bits and, without range checking, the upper bits are don't-care
  assign w_unused_bits = ^{bus.f_addr, bus.l_addr, 32'(DEPTH)};

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    wdata_d       = wdata_q;
    last_l_d      = last_l_q;
    bus.f_gnt     = 1'b0;
    bus.l_gnt     = 1'b0;
    bus.f_rvalid  = 1'b0;
    bus.f_rdata   = 32'h0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_idx   = '0;
    bus.mem_wdata = 32'h0;
    bus.err       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_pick[0]) begin
          bus.f_gnt = 1'b1;
          idx_d     = bus.f_addr[IDX_W+1:2];
          last_l_d  = 1'b0;
          state_d   = ST_READ;
        end else if (w_pick[1]) begin
          bus.l_gnt = 1'b1;
          idx_d     = bus.l_addr[IDX_W+1:2];
          wdata_d   = bus.l_wdata;
          last_l_d  = 1'b1;
          state_d   = ST_WRITE;
        end
      end
      ST_READ: begin
        if (!w_oor_hold) begin
          bus.mem_en  = 1'b1;
          bus.mem_idx = idx_q;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        bus.f_rvalid = 1'b1;
        bus.f_rdata  = w_oor_hold ? NOP_INSTR : bus.mem_rdata;
        bus.err      = w_oor_hold;
        state_d      = ST_IDLE;
      end
      ST_WRITE: begin
        if (!w_oor_hold) begin
          bus.mem_en    = 1'b1;
          bus.mem_we    = 1'b1;
          bus.mem_idx   = idx_q;
          bus.mem_wdata = wdata_q;
        end
        bus.err = w_oor_hold;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      wdata_q  <= 32'h0;
      last_l_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      last_l_q <= last_l_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_arbiter : directed + randomized bench with a transaction-level model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_imem_arbiter;
  import imem_pkg::*;

  localparam int DEPTH = 64;
  localparam int IDX_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_arbiter_if #(.IDX_W(IDX_W)) bus ();

  imem_arbiter #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural RAM: one-cycle read latency, garbage on the bus otherwise
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= ram[bus.mem_idx];
    else                           bus.mem_rdata <= $urandom;
    if (bus.mem_en && bus.mem_we)  ram[bus.mem_idx] <= bus.mem_wdata;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: each granted transaction schedules its future per-cycle outputs
  typedef struct {
    bit          en;
    bit          we;
    int unsigned idx;
    logic [31:0] wdata;
    bit          rv;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] ref_mem [DEPTH];
  bit          last_l = 1'b1;
  bit          mdl_fg = 1'b0;
  bit          mdl_lg = 1'b0;
  bit          chk_on = 1'b0;

  function automatic exp_t mk(bit en, bit we, int unsigned idx, logic [31:0] wd,
                              bit rv, logic [31:0] rd, bit er);
    exp_t r;
    r.en = en; r.we = we; r.idx = idx; r.wdata = wd; r.rv = rv; r.rdata = rd; r.err = er;
    return r;
  endfunction

  function automatic bit is_oor(logic [31:0] a);
`ifdef IMEM_ARB_RANGE_CHK_EN
    return (a >> 2) >= 32'(DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      int unsigned idx;
      bit idle;
      idle = (exp_q.size() == 0);
      e = mk(0, 0, 0, 0, 0, 0, 0);
      if (!idle) e = exp_q.pop_front();
      mdl_fg = 1'b0;
      mdl_lg = 1'b0;
      if (idle && !rst) begin
        mdl_fg = bus.f_req && (!bus.l_req || last_l);
        mdl_lg = bus.l_req && !mdl_fg;
      end
      check_eq("f_gnt",     bus.f_gnt,     mdl_fg);
      check_eq("l_gnt",     bus.l_gnt,     mdl_lg);
      check_eq("mem_en",    bus.mem_en,    e.en);
      check_eq("mem_we",    bus.mem_we,    e.we);
      check_eq("mem_idx",   bus.mem_idx,   e.idx);
      check_eq("mem_wdata", bus.mem_wdata, e.wdata);
      check_eq("f_rvalid",  bus.f_rvalid,  e.rv);
      check_eq("f_rdata",   bus.f_rdata,   e.rdata);
      check_eq("err",       bus.err,       e.err);

      if (rst) begin
        exp_q.delete();
        last_l = 1'b1;
      end else if (mdl_fg) begin
        idx    = (bus.f_addr >> 2) % DEPTH;
        last_l = 1'b0;
        if (is_oor(bus.f_addr)) begin
          exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
          exp_q.push_back(mk(0, 0, 0, 0, 1, NOP_INSTR, 1));
        end else begin
          exp_q.push_back(mk(1, 0, idx, 0, 0, 0, 0));
          exp_q.push_back(mk(0, 0, 0, 0, 1, ref_mem[idx], 0));
        end
      end else if (mdl_lg) begin
        idx    = (bus.l_addr >> 2) % DEPTH;
        last_l = 1'b1;
        if (is_oor(bus.l_addr)) begin
          exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        end else begin
          exp_q.push_back(mk(1, 1, idx, bus.l_wdata, 0, 0, 0));
          ref_mem[idx] = bus.l_wdata;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input bit fetch);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      #1;
      got = fetch ? mdl_fg : mdl_lg;
    end
    if (!got) check_eq("grant_timeout", got, 1);
    tick();
    if (fetch) bus.f_req = 1'b0;
    else       bus.l_req = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] a);
    bus.f_req  = 1'b1;
    bus.f_addr = a;
    wait_grant(1'b1);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    bus.l_req   = 1'b1;
    bus.l_addr  = a;
    bus.l_wdata = d;
    wait_grant(1'b0);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return {22'h0, 8'($urandom_range(0, DEPTH - 1)), 2'($urandom)};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] order;
    int         n_f, n_l, n_g;

    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[2]     = 32'h002081b3;
    ref_mem[2] = 32'h002081b3;
    bus.f_req = 0; bus.f_addr = 0; bus.l_req = 0; bus.l_addr = 0; bus.l_wdata = 0;

    rst = 1'b1;
    tick();
    chk_on = 1'b1;
    tick();
    rst = 1'b0;

    // Single fetch, loader write then read-back
    do_fetch(32'h08);
    repeat (3) tick();
    do_load(32'h24, 32'h02a00413);
    repeat (2) tick();
    do_fetch(32'h24);
    repeat (3) tick();

    // Both ports hammering from reset: fetch takes the first tie, then alternation
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.f_req = 1; bus.f_addr = 32'h10;
    bus.l_req = 1; bus.l_addr = 32'h30; bus.l_wdata = 32'h00500093;
    order = '0; n_f = 0; n_l = 0; n_g = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      #1;
      if (bus.f_gnt || bus.l_gnt) begin
        if (n_g < 4) order = {order[2:0], bus.f_gnt};
        n_g++;
        if (bus.f_gnt) n_f++;
        if (bus.l_gnt) n_l++;
      end
    end
    check_eq("rr_order", order, 4'b1010);
    check_eq("fetch_not_starved", (n_f > 1), 1);
    check_eq("loader_not_starved", (n_l > 1), 1);
    tick();
    bus.f_req = 0; bus.l_req = 0;
    repeat (3) tick();

    // Reset landing in the READ cycle, then in the WRITE cycle
    do_fetch(32'h0c);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (2) tick();
    do_load(32'h14, 32'hdeadbeef);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // Out-of-range addresses (wrap or blocked, depending on build)
    do_fetch(32'h100);
    repeat (3) tick();
    do_load(32'h104, 32'h12345678);
    repeat (2) tick();
    do_fetch(32'h04);
    repeat (3) tick();

    // Randomized traffic with occasional reset
    for (int c = 0; c < 1500; c++) begin
      if (bus.f_req && mdl_fg) bus.f_req = 1'b0;
      if (bus.l_req && mdl_lg) bus.l_req = 1'b0;
      if (!bus.f_req) begin
        bus.f_addr = rand_addr();
        if ($urandom_range(0, 2) == 0) bus.f_req = 1'b1;
      end
      if (!bus.l_req) begin
        bus.l_addr  = rand_addr();
        bus.l_wdata = $urandom;
        if ($urandom_range(0, 3) == 0) bus.l_req = 1'b1;
      end
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    bus.f_req = 0; bus.l_req = 0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
